// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display reader, which
// always wins, and a writer decoupled through a small FIFO write buffer.
// Reads are never stalled; buffered writes drain only in cycles the display
// leaves free. There is no forwarding from the buffer to reads.
module vram_arbiter #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_req,
  input  logic [AW-1:0]              rd_addr,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] buf_addr_q [DEPTH];
  logic [DW-1:0] buf_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_valid_q;
  logic [AW-1:0] last_addr_q;
  logic [DW-1:0] last_wdata_q;

  logic full, empty, push, pop;

  // Grant: display first, then buffer head; ready depends on state and rst only.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    wr_ready  = !rst && !full;
    push      = wr_valid && wr_ready;
    pop       = !rst && !rd_req && !empty;
    mem_en    = !rst && (rd_req || !empty);
    mem_we    = pop;
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    if (!rst && rd_req) begin
      mem_addr = rd_addr;
    end else if (pop) begin
      mem_addr  = buf_addr_q[rd_ptr_q];
      mem_wdata = buf_data_q[rd_ptr_q];
    end
  end

  // Next-state for occupancy and pointers; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset drops any buffered writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_req;
    end
  end

  // Buffer storage, written at the tail on an accepted write.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= wr_addr;
      buf_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Remember the last driven address/data so the bus holds while disabled.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      last_addr_q  <= mem_addr;
      last_wdata_q <= mem_wdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;
  assign level    = level_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a queue-based model of the write buffer plus a golden
// picture of VRAM contents, compared every cycle, with directed scenarios and
// a randomized phase.
module tb_vram_arbiter;
  localparam int AW = 15, DW = 12, DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rd_req, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic rd_valid, wr_ready, mem_en, mem_we;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [$clog2(DEPTH):0] level;

  int checks = 0, errors = 0;
  bit run_chk = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .level(level)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Physical VRAM: synchronous read, one-cycle latency; unwritten words read 0.
  logic [DW-1:0] ram [int];
  logic [DW-1:0] ram_q = '0;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we) ram_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
  end

  // Reference model: FIFO of pending writes and golden committed contents.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t q[$];
  logic [DW-1:0] gold [int];
  bit m_rd_valid = 0, have_addr = 0, have_wdata = 0;
  logic [DW-1:0] m_rd_exp = '0, last_wdata = '0;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rd_valid = 0;
    end else begin
      bit do_pop, do_push;
      do_pop  = !rd_req && q.size() > 0;
      do_push = wr_valid && q.size() < DEPTH;
      if (rd_req) begin
        last_addr = rd_addr;
        have_addr = 1;
        m_rd_exp  = gold.exists(int'(rd_addr)) ? gold[int'(rd_addr)] : '0;
      end
      if (do_pop) begin
        last_addr  = q[0].a;
        last_wdata = q[0].d;
        have_addr  = 1;
        have_wdata = 1;
        gold[int'(q[0].a)] = q[0].d;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{a: wr_addr, d: wr_data});
      m_rd_valid = rd_req;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      bit e_en, e_we;
      e_en = !rst && (rd_req || q.size() > 0);
      e_we = !rst && !rd_req && q.size() > 0;
      check("wr_ready", wr_ready, !rst && q.size() < DEPTH);
      check("level", level, q.size());
      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_we);
      check("rd_valid", rd_valid, m_rd_valid);
      if (m_rd_valid) check("rd_data", rd_data, m_rd_exp);
      if (e_en && !rst && rd_req) check("rd_addr_grant", mem_addr, rd_addr);
      else if (e_we) begin
        check("wr_head_addr", mem_addr, q[0].a);
        check("wr_head_data", mem_wdata, q[0].d);
      end else if (!e_en) begin
        if (have_addr)  check("hold_addr", mem_addr, last_addr);
        if (have_wdata) check("hold_wdata", mem_wdata, last_wdata);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1; rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    tick; tick;
    run_chk = 1;
    // Reset forces the bus and ready low even with a read pending.
    rd_req = 1; rd_addr = 15'h0033;
    #1 check("rst_mem_en", mem_en, 0); check("rst_ready", wr_ready, 0); check("rst_we", mem_we, 0);
    tick;
    rd_req = 0; rst = 0;
    #1 check("post_rst_level", level, 0); check("post_rst_ready", wr_ready, 1);
    tick;

    // Idle write: no bypass, commits the following cycle.
    wr_valid = 1; wr_addr = 15'h0010; wr_data = 12'hF00;
    #1 check("idle_no_bypass", mem_we, 0);
    tick;
    wr_valid = 0;
    #1 check("idle_we", mem_we, 1); check("idle_addr", mem_addr, 15'h0010);
    check("idle_wdata", mem_wdata, 12'hF00); check("idle_level1", level, 1);
    tick;
    #1 check("idle_level0", level, 0); check("idle_en_off", mem_en, 0);

    // Active video: 10 read cycles, writer offers 6 writes.
    n = 0; rd_req = 1;
    for (int c = 0; c < 10; c++) begin
      rd_addr = AW'($urandom_range(0, 15)) + 15'h0800;
      wr_valid = (n < 6); wr_addr = AW'(15'h0100 + n); wr_data = DW'(12'h200 + n);
      #1;
      if (wr_valid && wr_ready) n++;
      check("video_no_we", mem_we, 0);
      tick;
    end
    check("video_accepted", n, 4);
    check("video_full_level", level, 4);
    check("video_ready_low", wr_ready, 0);

    // Drain: queued writes commit in order, then the last two follow.
    rd_req = 0;
    for (int c = 0; c < 6; c++) begin
      wr_valid = (n < 6); wr_addr = AW'(15'h0100 + n); wr_data = DW'(12'h200 + n);
      #1;
      check("drain_we", mem_we, 1);
      check("drain_order", mem_addr, 15'h0100 + c);
      if (wr_valid && wr_ready) n++;
      tick;
    end
    wr_valid = 0;
    #1 check("drain_all", n, 6); check("drain_empty", level, 0);
    tick;

    // Read-after-write to the same address returns the old contents.
    rd_req = 1; rd_addr = 15'd5; wr_valid = 1; wr_addr = 15'd5; wr_data = 12'hABC;
    tick;
    rd_req = 0; wr_valid = 0;
    #1 check("raw_valid", rd_valid, 1); check("raw_old", rd_data, 12'h000);
    check("raw_commit_addr", mem_addr, 15'd5);
    tick;
    rd_req = 1; rd_addr = 15'd5;
    tick;
    rd_req = 0;
    #1 check("raw_new", rd_data, 12'hABC);
    tick;

    // Simultaneous push/pop at level 2 for 8 cycles.
    rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_addr = AW'(15'h0200 + i); wr_data = DW'(12'h300 + i);
      tick;
    end
    rd_req = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_addr = AW'(15'h0300 + i); wr_data = DW'(12'h400 + i);
      #1 check("pp_level", level, 2); check("pp_we", mem_we, 1);
      tick;
    end
    wr_valid = 0;
    tick; tick; tick;
    #1 check("pp_drained", level, 0);

    // Reset with three writes pending discards them.
    rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = AW'(15'h0400 + i); wr_data = DW'(12'h7A0 + i);
      tick;
    end
    wr_valid = 0;
    #1 check("rst3_level", level, 3);
    rd_req = 0; rst = 1;
    #1 check("rst3_no_we", mem_we, 0);
    tick;
    rst = 0;
    #1 check("rst3_level0", level, 0); check("rst3_no_we_after", mem_we, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; rd_addr = AW'(15'h0400 + i);
      tick;
      rd_req = 0;
      #1 check("rst3_discarded", rd_data, 12'h000);
      tick;
    end

    // Randomized traffic on a small address window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens     = (c / 200) % 3;
      rst      = ($urandom_range(0, 299) == 0);
      rd_req   = ($urandom_range(0, 9) < (dens == 0 ? 3 : (dens == 1 ? 6 : 9)));
      rd_addr  = AW'($urandom_range(0, 15));
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = DW'($urandom);
      tick;
    end
    rst = 0; rd_req = 0; wr_valid = 0;
    repeat (DEPTH + 2) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 15, framebuffer address width (160x120 = 19200 words).
REQ-002 Parameter DW, default 12, pixel word width (4-bit R, G, B).
REQ-003 Parameter DEPTH, default 4, write-buffer entries; power of two, at least 2.
REQ-004 Port clk, input, 1, single clock: the 25 MHz pixel clock from the clock divider.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port rd_req, input, 1, display read request from the pixel generator.
REQ-007 Port rd_addr, input, AW, display read address.
REQ-008 Port rd_valid, output, 1, rd_data is valid for the request of the previous cycle.
REQ-009 Port rd_data, output, DW, returned pixel word.
REQ-010 Port wr_valid, input, 1, writer presents a write.
REQ-011 Port wr_ready, output, 1, buffer can accept a write.
REQ-012 Port wr_addr, input, AW, write address.
REQ-013 Port wr_data, input, DW, write data.
REQ-014 Port mem_en, output, 1, single-port VRAM enable.
REQ-015 Port mem_we, output, 1, VRAM write enable.
REQ-016 Port mem_addr, output, AW, VRAM address.
REQ-017 Port mem_wdata, output, DW, VRAM write data.
REQ-018 Port mem_rdata, input, DW, VRAM read data; synchronous, valid 1 cycle after a read.
REQ-019 Port level, output, clog2(DEPTH)+1, current write-buffer occupancy.

Function
REQ-020 The block shall share one single-port VRAM between the display reader (absolute priority) and a buffered writer.
REQ-021 A write shall be accepted on a clk edge with wr_valid=1 and wr_ready=1; wr_addr and wr_data shall be pushed at the FIFO tail.
REQ-022 wr_ready shall equal (level != DEPTH) and shall be derived from registered state only, with no combinational path from wr_valid.
REQ-023 Per-cycle grant (combinational from inputs and registered state):
- if rd_req=1: mem_en=1, mem_we=0, mem_addr=rd_addr;
- else if level>0: mem_en=1, mem_we=1, mem_addr and mem_wdata are the FIFO head, and the head is popped at the edge;
- else mem_en=0 and mem_we=0.
REQ-024 The display shall never be stalled or delayed; rd_req shall always be granted in the cycle it is asserted.
REQ-025 rd_valid shall be rd_req registered by one cycle, and rd_data shall be mem_rdata passed through in that cycle.
REQ-026 Simultaneous push and pop shall leave level unchanged; the pointers shall wrap modulo DEPTH.
REQ-027 A write pushed into an empty buffer shall reach VRAM no earlier than the next cycle; there is no bypass.
REQ-028 Writes shall reach VRAM in acceptance order; same-address writes shall keep their order, and the last write wins.
REQ-029 A read of an address with a pending buffered write shall return the old VRAM contents; there is no forwarding.
REQ-030 When full and rd_req=1 continuously, wr_ready shall stay 0 and no buffer entry shall be lost or overwritten.
REQ-031 When mem_en=0, mem_addr and mem_wdata shall hold their last values; they carry no meaning while disabled.

Reset
REQ-032 While rst=1 at an edge, the block shall clear level, both pointers and rd_valid to 0.
REQ-033 While rst=1, mem_en, mem_we and wr_ready shall be forced to 0 combinationally.
REQ-034 Reset asserted mid-operation shall discard buffered writes: they are not committed, and no partial write is issued in the reset cycle.
REQ-035 In the first cycle after rst deasserts, wr_ready shall be 1 and level shall be 0.

Verification
REQ-036 Idle write: rd_req=0, one write of addr 0x0010, data 0xF00 -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0xF00; level 1->0.
REQ-037 Active video: rd_req=1 for 10 cycles while the writer pushes 6 writes -> 4 accepted, wr_ready=0 after the 4th, mem_we=0 throughout, rd_valid=1 on cycles 2-11.
REQ-038 Drain: after REQ-037, rd_req drops to 0 -> the 4 writes commit in order on 4 consecutive cycles and the remaining 2 are then accepted and committed.
REQ-039 Read-after-write: VRAM[5]=0x000, write 0xABC to addr 5 with rd_req=1 on addr 5 in the same cycle -> rd_data=0x000, and a later read returns 0xABC.
REQ-040 Push and pop together: level=2 with no rd_req and a push each cycle for 8 cycles -> level stays 2 and pointers wrap correctly.
REQ-041 Reset with level=3 -> level=0, no mem_we during or after the reset cycle, and the 3 writes are never committed.
